lcd_bus_arbiter: RTL and testbench

Shares the single HD44780-style character-LCD bus (rs/rw/en/data[7:0]) between several requesters, such as the power-up init sequencer, the opcode message writer and a status writer. It grants the bus round-robin, one byte at a time. It generates the enable pulse and the post-write busy delay itself, so requesters only present a byte and wait for `ack`. Requesters can hold a lock to make multi-byte sequences (clear plus a message) atomic.

---
 rtl/lcd_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780-style character-LCD bus between
// several requesters. Grants are round-robin, one byte at a time. The block
// generates the enable pulse and the post-write busy delay itself. A lock
// held by the current owner keeps the bus for multi-byte sequences.
module lcd_bus_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int EN_CYCLES = 20,
  parameter int T_CHAR    = 2500,
  parameter int T_LONG    = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   lock,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [7:0]           lcd_data
);

  localparam int MAX_A   = (T_LONG > EN_CYCLES) ? T_LONG : EN_CYCLES;
  localparam int CNT_MAX = (MAX_A > T_CHAR) ? MAX_A : T_CHAR;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] EN_LAST   = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(T_CHAR - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(T_LONG - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      owner_q, owner_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            long_q, long_d;

  logic [7:0]      req_pad, lock_pad, rs_pad;
  logic [7:0][7:0] data_pad;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic [3:0]      cand;
  logic            sel_rs;
  logic [7:0]      sel_data;
  logic            sel_long;

  // Widen the per-requester inputs to 8 slots so a 3-bit index is always in range
  always_comb begin
    req_pad                    = '0;
    lock_pad                   = '0;
    rs_pad                     = '0;
    data_pad                   = '0;
    req_pad[NUM_REQ-1:0]       = req;
    lock_pad[NUM_REQ-1:0]      = lock;
    rs_pad[NUM_REQ-1:0]        = req_rs;
    data_pad[NUM_REQ-1:0]      = req_data;
  end

  // Pick the winner: the locked owner only, else the first requester after the owner
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = owner_q;
    cand        = '0;
    if (lock_pad[owner_q]) begin
      grant_valid = req_pad[owner_q];
    end else begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        cand = {1'b0, owner_q} + 4'(i);
        if (cand >= 4'(NUM_REQ)) begin
          cand = cand - 4'(NUM_REQ);
        end
        if (req_pad[cand[2:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[2:0];
        end
      end
    end
  end

  // Fetch the winner's byte and decide whether it is a slow Clear/Home command
  always_comb begin
    sel_rs   = rs_pad[grant_idx];
    sel_data = data_pad[grant_idx];
    sel_long = !sel_rs && (sel_data == 8'h01 || sel_data == 8'h02 || sel_data == 8'h03);
  end

  // Next-state logic; the counter restarts from zero on every state change
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    owner_d    = owner_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    long_d     = long_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_valid) begin
          state_d    = SETUP;
          owner_d    = grant_idx;
          lcd_rs_d   = sel_rs;
          lcd_data_d = sel_data;
          long_d     = sel_long;
        end
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == (long_q ? LONG_LAST : CHAR_LAST)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and latched-byte registers; reset leaves requester 0 first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 3'(NUM_REQ - 1);
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
      long_q     <= long_d;
    end
  end

  // Outputs decoded straight from the state so reset clears them at once
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state_q == DONE) && (owner_q == 3'(i));
    end
    owner    = owner_q;
    busy     = (state_q != IDLE);
    lcd_en   = (state_q == PULSE);
    lcd_rw   = 1'b0;
    lcd_rs   = lcd_rs_q;
    lcd_data = lcd_data_q;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: table-driven and randomized checks of the LCD bus
// arbiter. Short delays keep each byte a few dozen cycles long.
module tb_lcd_bus_arbiter;

  localparam int N  = 3;
  localparam int EN = 12;
  localparam int TC = 10;
  localparam int TL = 40;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, reqRs, lock;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   ack;
  logic [2:0]     owner;
  logic           busy, lcdRs, lcdRw, lcdEn;
  logic [7:0]     lcdData;

  int checkCount = 0;
  int errorCount = 0;
  int modelOwner;

  typedef struct {
    int         g;
    logic       rs;
    logic [7:0] data;
    int         waitLen;
    bit         scramble;
  } vec_t;

  vec_t       vectors [7];
  logic [7:0] lockChars [4];
  int         rrOrder [4];
  logic [7:0] rrData [3];

  // 100 MHz bench clock
  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .NUM_REQ(N), .EN_CYCLES(EN), .T_CHAR(TC), .T_LONG(TL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rs(reqRs), .req_data(reqData),
    .lock(lock), .ack(ack), .owner(owner), .busy(busy), .lcd_rs(lcdRs),
    .lcd_rw(lcdRw), .lcd_en(lcdEn), .lcd_data(lcdData)
  );

  // Compare one value and count the result
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive all requester inputs at once
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] rs, input logic [8*N-1:0] d);
    req     = r;
    lock    = l;
    reqRs   = rs;
    reqData = d;
  endtask

  // Reference arbitration: the locked owner alone, else the first request after the owner
  function automatic int predictWinner();
    if (lock[modelOwner]) return req[modelOwner] ? modelOwner : -1;
    for (int off = 1; off <= N; off++) begin
      if (req[(modelOwner + off) % N]) return (modelOwner + off) % N;
    end
    return -1;
  endfunction

  // Follow one byte from grant to ack, measuring pulse and wait lengths
  task automatic runByte(input int g, input logic rs, input logic [7:0] data,
                         input int waitLen, input bit scramble);
    int n;
    int m;
    bit unstable;
    unstable = 1'b0;
    @(negedge clk);
    checkOutput("grantBusy", int'(busy), 1);
    checkOutput("grantOwner", int'(owner), g);
    checkOutput("setupEnLow", int'(lcdEn), 0);
    checkOutput("setupRs", int'(lcdRs), int'(rs));
    checkOutput("setupData", int'(lcdData), int'(data));
    n = 0;
    @(negedge clk);
    while (lcdEn && n < EN + 5) begin
      if (lcdData !== data || lcdRs !== rs) unstable = 1'b1;
      n++;
      @(negedge clk);
    end
    checkOutput("pulseLen", n, EN);
    m = 0;
    while (ack == '0 && busy && m < TL + 5) begin
      if (lcdData !== data || lcdRs !== rs || lcdEn) unstable = 1'b1;
      if (scramble && m == 1) begin
        reqData[8*g +: 8] = ~data;
        reqRs[g]          = ~rs;
      end
      m++;
      @(negedge clk);
    end
    checkOutput("waitLen", m, waitLen);
    checkOutput("dataStable", int'(unstable), 0);
    checkOutput("ackOneHot", int'(ack), 1 << g);
    @(negedge clk);
    checkOutput("ackWidth", int'(ack), 0);
    checkOutput("idleBusy", int'(busy), 0);
    checkOutput("holdData", int'(lcdData), int'(data));
  endtask

  // Predict the next grant from the model and check the DUT follows it
  task automatic grantAndCheck(input bit scramble);
    int         w;
    int         wl;
    int         idleBad;
    logic       r;
    logic [7:0] d;
    w = predictWinner();
    if (w < 0) begin
      idleBad = 0;
      repeat (3) begin
        @(negedge clk);
        if (busy) idleBad = 1;
      end
      checkOutput("noGrant", idleBad, 0);
    end else begin
      modelOwner = w;
      r  = reqRs[w];
      d  = reqData[8*w +: 8];
      wl = (r == 1'b0 && d >= 8'h01 && d <= 8'h03) ? TL : TC;
      runByte(w, r, d, wl, scramble);
    end
  endtask

  // Hard stop in case the DUT wedges somewhere the bounded loops do not cover
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence
  initial begin
    int         n;
    logic [2:0] rv;
    logic [2:0] lv;
    logic [2:0] sv;
    logic [23:0] dv;

    vectors[0] = '{1, 1'b1, 8'h41, TC, 1'b0};
    vectors[1] = '{0, 1'b0, 8'h02, TL, 1'b0};
    vectors[2] = '{2, 1'b0, 8'h80, TC, 1'b0};
    vectors[3] = '{1, 1'b1, 8'h01, TC, 1'b0};
    vectors[4] = '{0, 1'b0, 8'h03, TL, 1'b1};
    vectors[5] = '{2, 1'b0, 8'h04, TC, 1'b1};
    vectors[6] = '{1, 1'b0, 8'h00, TC, 1'b0};
    lockChars  = '{8'h4C, 8'h4F, 8'h41, 8'h44};
    rrOrder    = '{0, 1, 2, 0};
    rrData     = '{8'hA0, 8'hB1, 8'hC2};

    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0);
    modelOwner = N - 1;
    repeat (3) @(negedge clk);
    checkOutput("resetEn", int'(lcdEn), 0);
    checkOutput("resetRs", int'(lcdRs), 0);
    checkOutput("resetRw", int'(lcdRw), 0);
    checkOutput("resetData", int'(lcdData), 0);
    checkOutput("resetAck", int'(ack), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetOwner", int'(owner), N - 1);
    rst_n = 1'b1;

    // Requester 2 owns the bus after reset and locks it for five bytes
    applyStimulus(3'b101, 3'b100, 3'b001, {8'h01, 8'h00, 8'h30});
    runByte(2, 1'b0, 8'h01, TL, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b101, 3'b100, 3'b101, {lockChars[i], 8'h00, 8'h30});
      runByte(2, 1'b1, lockChars[i], TC, 1'b0);
    end
    modelOwner = 2;
    applyStimulus(3'b001, 3'b100, 3'b001, {8'h00, 8'h00, 8'h30});
    grantAndCheck(1'b0);
    applyStimulus(3'b001, 3'b000, 3'b001, {8'h00, 8'h00, 8'h30});
    runByte(0, 1'b1, 8'h30, TC, 1'b0);

    // Single-requester vectors, including the long-delay decode cases
    for (int i = 0; i < 7; i++) begin
      rv = 3'(1 << vectors[i].g);
      sv = vectors[i].rs ? rv : 3'b000;
      dv = 24'(vectors[i].data) << (8 * vectors[i].g);
      applyStimulus(rv, 3'b000, sv, dv);
      runByte(vectors[i].g, vectors[i].rs, vectors[i].data, vectors[i].waitLen,
              vectors[i].scramble);
    end
    modelOwner = 1;
    applyStimulus('0, '0, '0, '0);

    // Round-robin with every requester pending from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b111, 3'b000, 3'b010, {rrData[2], rrData[1], rrData[0]});
    for (int i = 0; i < 4; i++) begin
      runByte(rrOrder[i], (rrOrder[i] == 1), rrData[rrOrder[i]], TC, 1'b0);
    end
    modelOwner = 0;
    applyStimulus('0, '0, '0, '0);

    // Reset pulled low on the 10th cycle of the enable pulse
    @(negedge clk);
    applyStimulus(3'b010, 3'b000, 3'b010, {8'h00, 8'h55, 8'h00});
    n = 0;
    while (!lcdEn && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resetPulseStart", int'(lcdEn), 1);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetEn", int'(lcdEn), 0);
    checkOutput("midResetBusy", int'(busy), 0);
    checkOutput("midResetAck", int'(ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelOwner = N - 1;
    grantAndCheck(1'b0);
    applyStimulus('0, '0, '0, '0);

    // Randomized traffic checked against the arbitration model
    for (int it = 0; it < 30; it++) begin
      rv = 3'($urandom_range(0, 7));
      lv = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      sv = 3'($urandom_range(0, 7));
      for (int b = 0; b < N; b++) begin
        dv[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                   : 8'($urandom_range(0, 255));
      end
      applyStimulus(rv, lv, sv, dv);
      grantAndCheck(1'($urandom_range(0, 1)));
    end
    applyStimulus('0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
